// File: rtl/gyro_angle_integrator.sv
// Three-axis gyro rate integrator: averages a zero-rate bias per axis, then
// integrates bias-corrected, deadbanded rates into saturating angle accumulators.
module gyro_angle_integrator #(
  parameter int SAMPLE_DIV  = 1000000,
  parameter int CAL_SHIFT   = 6,
  parameter int DEADBAND    = 16,
  parameter int ACC_W       = 40,
  parameter int ANGLE_SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rate_x,
  input  logic [15:0] rate_y,
  input  logic [15:0] rate_z,
  input  logic        cal_req,
  input  logic        zero_req,
  output logic [15:0] angle_x,
  output logic [15:0] angle_y,
  output logic [15:0] angle_z,
  output logic [15:0] bias_x,
  output logic [15:0] bias_y,
  output logic [15:0] bias_z,
  output logic        cal_done,
  output logic        sample_valid
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SUM_W = CAL_SHIFT + 16;
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [16:0] DB = 17'(DEADBAND);

  typedef enum logic {CAL, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CAL_SHIFT-1:0]    cal_cnt_q, cal_cnt_d;
  logic                    cal_done_q, cal_done_d;
  logic                    sample_valid_q, sample_valid_d;
  logic signed [SUM_W-1:0] sum_q [3], sum_d [3], sum_nxt [3];
  logic signed [15:0]      bias_q [3], bias_d [3];
  logic signed [15:0]      angle_q [3], angle_d [3];
  logic signed [ACC_W-1:0] acc_q [3], acc_d [3], acc_nxt [3];
  logic signed [16:0]      diff [3];
  logic signed [15:0]      rate [3];
  logic                    tick;

  function automatic logic signed [16:0] deadband(input logic signed [16:0] d);
    deadband = (d <= DB && d >= -DB) ? 17'sd0 : d;
  endfunction

  // One extra headroom bit: the two top bits disagree only on overflow.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      sat_acc = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-16:0] top;
    top = v[ACC_W-1:15];
    if (&top || ~|top) sat16 = v[15:0];
    else               sat16 = v[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
  endfunction

  assign rate[0] = rate_x;
  assign rate[1] = rate_y;
  assign rate[2] = rate_z;
  assign tick    = (cnt_q == TICK_AT);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_nxt[i] = sum_q[i] + SUM_W'(rate[i]);
      diff[i]    = deadband(17'(rate[i]) - 17'(bias_q[i]));
      acc_nxt[i] = sat_acc((ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(diff[i]));
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = tick ? '0 : cnt_q + 1'b1;
    cal_cnt_d      = cal_cnt_q;
    cal_done_d     = cal_done_q;
    sample_valid_d = 1'b0;
    sum_d          = sum_q;
    bias_d         = bias_q;
    angle_d        = angle_q;
    acc_d          = acc_q;
    if (cal_req) begin
      state_d    = CAL;
      cal_done_d = 1'b0;
      cal_cnt_d  = '0;
      for (int i = 0; i < 3; i++) begin
        sum_d[i]   = '0;
        acc_d[i]   = '0;
        angle_d[i] = '0;
      end
    end else if (zero_req && state_q == RUN) begin
      for (int i = 0; i < 3; i++) begin
        acc_d[i]   = '0;
        angle_d[i] = '0;
      end
    end else if (tick && state_q == CAL) begin
      cal_cnt_d = cal_cnt_q + 1'b1;
      sum_d     = sum_nxt;
      // The final sample is folded in before the divide, not after.
      if (&cal_cnt_q) begin
        state_d    = RUN;
        cal_done_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          bias_d[i] = 16'(sum_nxt[i] >>> CAL_SHIFT);
          sum_d[i]  = '0;
        end
      end
    end else if (tick) begin
      sample_valid_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
        acc_d[i]   = acc_nxt[i];
        angle_d[i] = sat16(acc_nxt[i] >>> ANGLE_SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CAL;
      cnt_q          <= '0;
      cal_cnt_q      <= '0;
      cal_done_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sum_q[i]   <= '0;
        bias_q[i]  <= '0;
        angle_q[i] <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cal_cnt_q      <= cal_cnt_d;
      cal_done_q     <= cal_done_d;
      sample_valid_q <= sample_valid_d;
      for (int i = 0; i < 3; i++) begin
        sum_q[i]   <= sum_d[i];
        bias_q[i]  <= bias_d[i];
        angle_q[i] <= angle_d[i];
        acc_q[i]   <= acc_d[i];
      end
    end
  end

  assign angle_x      = angle_q[0];
  assign angle_y      = angle_q[1];
  assign angle_z      = angle_q[2];
  assign bias_x       = bias_q[0];
  assign bias_y       = bias_q[1];
  assign bias_z       = bias_q[2];
  assign cal_done     = cal_done_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_gyro_angle_integrator.sv
// Scoreboard bench for gyro_angle_integrator: a behavioural model queues the
// expected outputs for every cycle driven; they are compared after each edge.
module tb_gyro_angle_integrator;

  localparam int SAMPLE_DIV  = 4;
  localparam int CAL_SHIFT   = 2;
  localparam int DEADBAND    = 2;
  localparam int ACC_W       = 20;
  localparam int ANGLE_SHIFT = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1, cal_req = 1'b0, zero_req = 1'b0;
  logic [15:0] rate_x = '0, rate_y = '0, rate_z = '0;
  logic [15:0] angle_x, angle_y, angle_z, bias_x, bias_y, bias_z;
  logic        cal_done, sample_valid;

  gyro_angle_integrator #(
    .SAMPLE_DIV(SAMPLE_DIV), .CAL_SHIFT(CAL_SHIFT), .DEADBAND(DEADBAND),
    .ACC_W(ACC_W), .ANGLE_SHIFT(ANGLE_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .rate_x(rate_x), .rate_y(rate_y), .rate_z(rate_z),
    .cal_req(cal_req), .zero_req(zero_req),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
    .bias_x(bias_x), .bias_y(bias_y), .bias_z(bias_z),
    .cal_done(cal_done), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ang [3];
    longint bias [3];
    bit     done;
    bit     sv;
  } exp_t;

  exp_t   sb_q [$];
  int     n_vec = 0, n_miss = 0;

  int     m_cnt = 0, m_calcnt = 0;
  bit     m_run = 0, m_done = 0, m_sv = 0, last_tick = 0;
  longint m_sum [3], m_bias [3], m_acc [3], m_angle [3];

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic clear_model(input bit clr_bias);
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_acc[i] = 0; m_angle[i] = 0;
      if (clr_bias) m_bias[i] = 0;
    end
    m_calcnt = 0; m_run = 0; m_done = 0; m_sv = 0;
  endtask

  task automatic model_step();
    longint r [3];
    longint d;
    bit     tk;
    exp_t   e;
    r[0] = longint'($signed(rate_x));
    r[1] = longint'($signed(rate_y));
    r[2] = longint'($signed(rate_z));
    tk = (m_cnt == SAMPLE_DIV - 1);
    last_tick = tk && !rst;
    if (rst) begin
      clear_model(1);
      m_cnt = 0;
    end else begin
      m_cnt = tk ? 0 : m_cnt + 1;
      m_sv = 0;
      if (cal_req) begin
        clear_model(0);
      end else if (zero_req && m_run) begin
        for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_angle[i] = 0; end
      end else if (tk && !m_run) begin
        for (int i = 0; i < 3; i++) m_sum[i] += r[i];
        if (m_calcnt == (1 << CAL_SHIFT) - 1) begin
          for (int i = 0; i < 3; i++) begin
            m_bias[i] = m_sum[i] >>> CAL_SHIFT;
            m_sum[i]  = 0;
          end
          m_calcnt = 0; m_run = 1; m_done = 1;
        end else begin
          m_calcnt++;
        end
      end else if (tk) begin
        for (int i = 0; i < 3; i++) begin
          d = r[i] - m_bias[i];
          if (d <= DEADBAND && d >= -DEADBAND) d = 0;
          m_acc[i]   = clamp(m_acc[i] + d, -(longint'(1) << (ACC_W - 1)),
                             (longint'(1) << (ACC_W - 1)) - 1);
          m_angle[i] = clamp(m_acc[i] >>> ANGLE_SHIFT, -32768, 32767);
        end
        m_sv = 1;
      end
    end
    e.ang = m_angle; e.bias = m_bias; e.done = m_done; e.sv = m_sv;
    sb_q.push_back(e);
  endtask

  // Drive one cycle (inputs already set at the falling edge), then score it.
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("angle_x", longint'($signed(angle_x)), e.ang[0]);
    chk("angle_y", longint'($signed(angle_y)), e.ang[1]);
    chk("angle_z", longint'($signed(angle_z)), e.ang[2]);
    chk("bias_x", longint'($signed(bias_x)), e.bias[0]);
    chk("bias_y", longint'($signed(bias_y)), e.bias[1]);
    chk("bias_z", longint'($signed(bias_z)), e.bias[2]);
    chk("cal_done", longint'(cal_done), longint'(e.done));
    chk("sample_valid", longint'(sample_valid), longint'(e.sv));
    @(negedge clk);
  endtask

  task automatic tick_once();
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!last_tick && k < 2 * SAMPLE_DIV);
    chk("tick_timeout", longint'(last_tick), 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic align();
    int k = 0;
    while (m_cnt != SAMPLE_DIV - 1 && k < 2 * SAMPLE_DIV) begin
      cyc();
      k++;
    end
  endtask

  task automatic set_rates(input int x, input int y, input int z);
    rate_x = 16'(x); rate_y = 16'(y); rate_z = 16'(z);
  endtask

  task automatic chk_ax(input string tag, input longint v);
    chk(tag, longint'($signed(angle_x)), v);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_cal_done", longint'(cal_done), 0);
    chk("rst_bias_x", longint'($signed(bias_x)), 0);

    // Calibration: bias x=11, y=-5, z=floor(-21/4)=-6.
    for (int k = 0; k < 4; k++) begin
      set_rates(10 + k, -5, (k == 0) ? -21 : 0);
      tick_once();
    end
    chk("cal_bias_x", longint'($signed(bias_x)), 11);
    chk("cal_bias_y", longint'($signed(bias_y)), -5);
    chk("cal_bias_z", longint'($signed(bias_z)), -6);
    chk("cal_done_hi", longint'(cal_done), 1);

    // Integration at d=100.
    set_rates(111, -5, -6);
    for (int k = 1; k <= 3; k++) begin
      tick_once();
      chk_ax("int_angle", 100 * k);
      chk("int_valid", longint'(sample_valid), 1);
    end
    cyc();
    chk("valid_pulse_low", longint'(sample_valid), 0);

    // Deadband edges.
    set_rates(13, -5, -6); tick_once(); chk_ax("db_d2", 300);
    set_rates(14, -5, -6); tick_once(); chk_ax("db_d3", 303);
    set_rates(8, -5, -6);  tick_once(); chk_ax("db_dm3", 300);

    // Saturation up, recovery down to negative saturation, recovery up.
    zero_req = 1'b1; cyc(); zero_req = 1'b0;
    chk_ax("zero_angle", 0);
    set_rates(32767, -5, -6);
    tick_once(); chk_ax("sat_t1", 32756);
    tick_once(); chk_ax("sat_t2", 32767);
    ticks(18);
    set_rates(-32768, -5, -6);
    ticks(14); chk_ax("sat_hold", 32767);
    tick_once(); chk_ax("sat_recover", 32602);
    ticks(25); chk_ax("sat_neg", -32768);
    set_rates(32767, -5, -6);
    ticks(16); chk_ax("neg_recover", -192);

    // zero_req coincident with a tick drops that sample.
    set_rates(111, -5, -6);
    align();
    zero_req = 1'b1; cyc(); zero_req = 1'b0;
    chk_ax("zero_tick_angle", 0);
    chk("zero_tick_valid", longint'(sample_valid), 0);
    chk("zero_bias_x", longint'($signed(bias_x)), 11);
    tick_once(); chk_ax("zero_next", 100);

    // Recalibration keeps the old bias until it completes.
    ticks(2); chk_ax("pre_cal", 300);
    align();
    cal_req = 1'b1; cyc(); cal_req = 1'b0;
    chk("recal_done", longint'(cal_done), 0);
    chk_ax("recal_angle", 0);
    chk("recal_bias_hold", longint'($signed(bias_x)), 11);
    set_rates(20, -5, -6);
    ticks(3);
    chk("recal_mid_bias", longint'($signed(bias_x)), 11);
    tick_once();
    chk("recal_bias_x", longint'($signed(bias_x)), 20);
    chk("recal_done_hi", longint'(cal_done), 1);

    // rst mid-calibration restarts the sample count.
    cal_req = 1'b1; cyc(); cal_req = 1'b0;
    ticks(2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_mid_bias_x", longint'($signed(bias_x)), 0);
    chk("rst_mid_done", longint'(cal_done), 0);
    ticks(2);
    chk("restart_not_done", longint'(cal_done), 0);
    ticks(2);
    chk("restart_bias_x", longint'($signed(bias_x)), 20);
    chk("restart_done", longint'(cal_done), 1);
    tick_once();
    chk_ax("restart_run", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gyro_angle_integrator.md
Name: gyro_angle_integrator

Overview:
- Downstream consumer of the Pmod GYRO controller's data_x/data_y/data_z words (signed 16-bit angular rate, little-endian bytes already assembled).
- Samples the three rates on a fixed internal tick and calibrates the per-axis zero-rate bias by averaging.
- Subtracts the bias, applies a deadband, and integrates each axis into a saturating angle accumulator.
- Presents the scaled signed 16-bit angles to display/game logic.

Parameters:
- SAMPLE_DIV, 1000000, clk cycles per sample tick (100 Hz at 100 MHz); minimum 2.
- CAL_SHIFT, 6, log2 of the calibration sample count (64 samples).
- DEADBAND, 16, magnitude at or below which a bias-corrected rate counts as zero.
- ACC_W, 40, accumulator width (signed); must be at least 18.
- ANGLE_SHIFT, 16, arithmetic right shift from accumulator to angle output.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rate_x  in  16  signed X rate (data_x of controller)
- rate_y  in  16  signed Y rate
- rate_z  in  16  signed Z rate
- cal_req  in  1  single-cycle pulse: restart bias calibration
- zero_req  in  1  single-cycle pulse: clear angles, keep bias
- angle_x  out  16  signed integrated X angle
- angle_y  out  16  signed integrated Y angle
- angle_z  out  16  signed integrated Z angle
- bias_x  out  16  signed calibrated X bias
- bias_y  out  16  signed calibrated Y bias
- bias_z  out  16  signed calibrated Z bias
- cal_done  out  1  high while in RUN
- sample_valid  out  1  one-cycle pulse when angles update

Behaviour:
Reset
- All outputs are 0; state is CAL.
- Tick counter, calibration sample counter, calibration sums and accumulators are 0.

Tick
- The counter counts 0..SAMPLE_DIV-1 and wraps. tick is high in the cycle where the count equals SAMPLE_DIV-1.
- The counter is free-running; only rst clears it. cal_req and zero_req do not affect it.
- Rates are sampled combinationally in the tick cycle. Inputs are not synchronised, because the controller shares clk.

State CAL
- On each tick: sum_a += sign-extended rate_a, with sums CAL_SHIFT+16 bits wide, and the sample counter is incremented.
- On the tick where the counter equals 2^CAL_SHIFT-1, that sample is included: bias_a <= (sum_a + rate_a) >>> CAL_SHIFT, which is an arithmetic floor. In the same cycle: state <= RUN, cal_done <= 1, sums and counter are cleared.
- angle_* stay 0 throughout CAL. sample_valid stays 0.

State RUN
- On each tick, per axis:
  - d = rate_a - bias_a, computed at 17-bit signed.
  - If |d| <= DEADBAND, then d = 0.
  - acc_a <= sat_ACC_W(acc_a + sext(d)), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - angle_a <= sat16(next_acc_a >>> ANGLE_SHIFT).
- angle, acc and sample_valid update at the same edge, so sample_valid is high the cycle after tick. Latency from tick to the new angle is 1 clk.

Priority (in a single cycle): rst > cal_req > zero_req > tick.
- cal_req in any state: state <= CAL, cal_done <= 0, sums/counter/acc/angles <= 0. bias_* hold their old values until the new calibration completes. A coincident tick is discarded.
- zero_req in RUN: acc and angles <= 0, sample_valid <= 0, bias is kept. A coincident tick sample is dropped.
- zero_req in CAL: ignored.
- Mid-calibration rst or cal_req restarts the sample count from 0.
- A saturated accumulator holds at its limit and recovers when d changes sign. There is no wrap-around anywhere.

Test Plan:
Bench parameters: SAMPLE_DIV=4, CAL_SHIFT=2, DEADBAND=2, ACC_W=20, ANGLE_SHIFT=0.
1. Reset then calibration: rate_x=10,11,12,13 on 4 ticks; rate_y=-5 constant; rate_z=-21,0,0,0 -> after the 4th tick bias_x=11, bias_y=-5, bias_z=-6, cal_done=1, angles 0, no sample_valid during CAL.
2. Integration: with the step 1 bias, rate_x=111 for 3 ticks -> sample_valid pulses 1 clk after each tick; angle_x=100, 200, 300.
3. Deadband: rate_x=13 (d=2) -> angle_x unchanged. rate_x=14 (d=3) -> angle_x +3. rate_x=8 (d=-3) -> -3.
4. Saturation: rate_x=32767 (d=32756) -> angle_x=32756 after 1 tick, 32767 from tick 2 on; acc clamps at 524287 after tick 17. Then rate_x=-32768 -> acc decreases from 524287, with no wrap.
5. zero_req coincident with tick in RUN -> angles 0, that sample dropped, bias unchanged, next tick integrates normally.
6. cal_req after 2 RUN ticks -> cal_done=0, angles 0, old bias held. Calibration with rate_x=20 constant -> bias_x=20 after 4 ticks. Repeat with rst asserted after 2 calibration ticks -> full reset to 0, CAL restarts.
